output_port_allocator: RTL and testbench

//  Per-output-port switch allocator for the mesh Router; one instance per output (NUM_OF_PORTS per router).

---
 rtl/output_port_allocator_pkg.sv | 21 ++
 rtl/output_port_allocator_rr_picker.sv | 39 +++
 rtl/output_port_allocator.sv | 125 ++++++++++++
 tb/tb_output_port_allocator.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_port_allocator_pkg.sv
// Shared types for the router output-port allocator and its round-robin picker.
package output_port_allocator_pkg;

    localparam int unsigned NUM_OF_PORTS = 5;
    localparam int unsigned PORT_IDX_W   = $clog2(NUM_OF_PORTS);

    typedef enum logic [1:0] {
        HEAD,
        BODY,
        TAIL,
        HEAD_TAIL
    } flit_type_t;

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    typedef enum logic {
        ALLOC_IDLE,
        ALLOC_LOCKED
    } alloc_state_t;

endpackage

// File: rtl/output_port_allocator_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module output_port_allocator_rr_picker
    import output_port_allocator_pkg::*;
#(
    parameter int unsigned N     = NUM_OF_PORTS,
    parameter int unsigned IDX_W = PORT_IDX_W
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    // Two descending sweeps: the wrapped region (below ptr) first, then the region at or
    // above ptr, so the last write is the lowest index at/above ptr when one exists.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int c = int'(N) - 1; c >= 0; c--) begin
            if (req[c] && (IDX_W'(c) < ptr)) begin
                grant     = '0;
                grant[c]  = 1'b1;
                grant_idx = IDX_W'(c);
                any       = 1'b1;
            end
        end
        for (int c = int'(N) - 1; c >= 0; c--) begin
            if (req[c] && (IDX_W'(c) >= ptr)) begin
                grant     = '0;
                grant[c]  = 1'b1;
                grant_idx = IDX_W'(c);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_port_allocator.sv
// Per-output wormhole switch allocator: round-robin head arbitration, packet lock
// from head to tail, transfer gated by downstream on/off.
module output_port_allocator
    import output_port_allocator_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = NUM_OF_PORTS,
    parameter int unsigned PORT_ID     = 0,
    parameter bit          ALLOW_UTURN = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_PORTS-1:0]         i_req,
    input  logic [NUM_PORTS-1:0]         i_head,
    input  logic [NUM_PORTS-1:0]         i_tail,
    input  logic                         i_downstream_on,
    output logic [NUM_PORTS-1:0]         o_grant,
    output logic [$clog2(NUM_PORTS)-1:0] o_grant_idx,
    output logic                         o_locked,
    output logic [NUM_PORTS-1:0]         o_fire,
    output logic                         o_fire_tail
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);
    localparam logic [NUM_PORTS-1:0] UTURN_MASK =
        ALLOW_UTURN ? '0 : (NUM_PORTS'(1) << PORT_ID);

    alloc_state_t         state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;

    logic [NUM_PORTS-1:0] elig;
    logic [NUM_PORTS-1:0] pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 owner_req;
    logic                 owner_tail;
    logic                 xfer;

    // Only head flits may open a packet; our own input is masked unless U-turns are allowed.
    assign elig = i_req & i_head & ~UTURN_MASK;

    output_port_allocator_rr_picker #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req       (elig),
        .ptr       (ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // Owner's request/tail selected through the one-hot grant (zero when idle).
    assign owner_req  = |(i_req & grant_q);
    assign owner_tail = |(i_tail & grant_q);
    assign xfer       = (state_q == ALLOC_LOCKED) && owner_req && i_downstream_on;

    // State, round-robin pointer and owner registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ALLOC_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
        end
    end

    // Next state: arbitrate in IDLE, hold the owner until its tail flit transfers.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        case (state_q)
            ALLOC_IDLE: begin
                if (pick_any) begin
                    state_d = ALLOC_LOCKED;
                    grant_d = pick_grant;
                    idx_d   = pick_idx;
                end
            end
            ALLOC_LOCKED: begin
                if (xfer && owner_tail) begin
                    state_d = ALLOC_IDLE;
                    grant_d = '0;
                    idx_d   = '0;
                    ptr_d   = (idx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ALLOC_IDLE;
                grant_d = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Transfer strobes follow the current owner, inputs and downstream state in the same cycle.
    always_comb begin
        o_fire      = '0;
        o_fire_tail = 1'b0;
        if (xfer) begin
            o_fire      = grant_q;
            o_fire_tail = owner_tail;
        end
    end

    assign o_grant     = grant_q;
    assign o_grant_idx = idx_q;
    assign o_locked    = (state_q == ALLOC_LOCKED);

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(o_grant));
    a_fire_owner_only : assert property (@(posedge clk) disable iff (!reset_n)
        (o_fire & ~o_grant) == '0);
    a_lock_matches_grant : assert property (@(posedge clk) disable iff (!reset_n)
        o_locked == (o_grant != '0));

endmodule

// File: tb/tb_output_port_allocator.sv
// Self-checking bench for output_port_allocator: upstream flit queues drive requests,
// expected transfers are queued ahead and checked as the allocator fires.
module tb_output_port_allocator;
    import output_port_allocator_pkg::*;

    localparam int NP = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NP-1:0] req, head, tail;
    logic          down_on;
    logic [NP-1:0] grant, fire;
    logic [2:0]    grant_idx;
    logic          locked, fire_tail;

    logic [NP-1:0] b_req, b_head, b_tail;
    logic [NP-1:0] n_grant, n_fire, u_grant, u_fire;
    logic [2:0]    n_idx, u_idx;
    logic          n_locked, n_fire_tail, u_locked, u_fire_tail;

    always #5 clk = ~clk;

    output_port_allocator #(.NUM_PORTS(NP), .PORT_ID(0), .ALLOW_UTURN(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .i_req(req), .i_head(head), .i_tail(tail),
        .i_downstream_on(down_on), .o_grant(grant), .o_grant_idx(grant_idx),
        .o_locked(locked), .o_fire(fire), .o_fire_tail(fire_tail));

    output_port_allocator #(.NUM_PORTS(NP), .PORT_ID(1), .ALLOW_UTURN(1'b0)) u_no_uturn (
        .clk(clk), .reset_n(reset_n), .i_req(b_req), .i_head(b_head), .i_tail(b_tail),
        .i_downstream_on(down_on), .o_grant(n_grant), .o_grant_idx(n_idx),
        .o_locked(n_locked), .o_fire(n_fire), .o_fire_tail(n_fire_tail));

    output_port_allocator #(.NUM_PORTS(NP), .PORT_ID(1), .ALLOW_UTURN(1'b1)) u_uturn (
        .clk(clk), .reset_n(reset_n), .i_req(b_req), .i_head(b_head), .i_tail(b_tail),
        .i_downstream_on(down_on), .o_grant(u_grant), .o_grant_idx(u_idx),
        .o_locked(u_locked), .o_fire(u_fire), .o_fire_tail(u_fire_tail));

    typedef struct {
        int   idx;
        logic is_tail;
    } fire_t;

    int         n_checks = 0;
    int         n_pass = 0;
    flit_type_t flit_q[NP][$];
    fire_t      exp_q[$];
    logic [NP-1:0] req_mask;

    logic [NP-1:0] o_g, o_f;
    logic [2:0]    o_gi;
    logic          o_l, o_ft;

    // Present each input's head-of-queue flit unless the input is forced quiet.
    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            if (flit_q[p].size() > 0 && !req_mask[p]) begin
                req[p]  = 1'b1;
                head[p] = (flit_q[p][0] == HEAD) || (flit_q[p][0] == HEAD_TAIL);
                tail[p] = (flit_q[p][0] == TAIL) || (flit_q[p][0] == HEAD_TAIL);
            end else begin
                req[p]  = 1'b0;
                head[p] = 1'b0;
                tail[p] = 1'b0;
            end
        end
    endtask

    // One cycle: drive, sample at the falling edge, then dequeue what was transferred.
    task automatic tick();
        drive();
        @(negedge clk);
        o_g  = grant;
        o_gi = grant_idx;
        o_l  = locked;
        o_f  = fire;
        o_ft = fire_tail;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++)
            if (o_f[p] && flit_q[p].size() > 0) void'(flit_q[p].pop_front());
    endtask

    task automatic apply_reset();
        reset_n  = 1'b0;
        for (int p = 0; p < NP; p++) flit_q[p].delete();
        exp_q.delete();
        req_mask = '0;
        down_on  = 1'b1;
        b_req    = '0;
        b_head   = '0;
        b_tail   = '0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        reset_n = 1'b0;
        #2;
        n_checks++;
        if ({grant, grant_idx, locked, fire, fire_tail} !== '0)
            $display("FAIL reset_values grant=%b idx=%0d locked=%b fire=%b required all zero",
                     grant, grant_idx, locked, fire);
        else n_pass++;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if ({o_g, o_gi, o_l, o_f, o_ft} !== '0)
                $display("FAIL idle_no_req cyc%0d grant=%b idx=%0d locked=%b fire=%b required all zero",
                         c, o_g, o_gi, o_l, o_f);
            else n_pass++;
        end
    endtask

    task automatic test_packet();
        logic [NP-1:0] eg [6]  = '{5'd0, 5'd4, 5'd4, 5'd4, 5'd4, 5'd0};
        logic [NP-1:0] ef [6]  = '{5'd0, 5'd4, 5'd4, 5'd4, 5'd4, 5'd0};
        logic          eft [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [NP-1:0] eg2 [5] = '{5'd0, 5'd8, 5'd0, 5'd2, 5'd0};
        fire_t e;
        apply_reset();
        flit_q[2].push_back(HEAD);
        flit_q[2].push_back(BODY);
        flit_q[2].push_back(BODY);
        flit_q[2].push_back(TAIL);
        for (int k = 0; k < 4; k++) exp_q.push_back('{2, k == 3});
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++;
            if ({o_g, o_l, o_f, o_ft} !== {eg[c], eg[c] != '0, ef[c], eft[c]})
                $display("FAIL packet cyc%0d grant=%b locked=%b fire=%b tail=%b required grant=%b fire=%b tail=%b",
                         c, o_g, o_l, o_f, o_ft, eg[c], ef[c], eft[c]);
            else n_pass++;
            if (o_f != '0) begin
                n_checks++;
                if (exp_q.size() == 0)
                    $display("FAIL packet_sb cyc%0d unexpected fire=%b", c, o_f);
                else begin
                    e = exp_q.pop_front();
                    if (o_f !== (NP'(1) << e.idx) || o_ft !== e.is_tail || o_gi !== 3'(e.idx))
                        $display("FAIL packet_sb cyc%0d fire=%b tail=%b idx=%0d required input %0d tail=%b",
                                 c, o_f, o_ft, o_gi, e.idx, e.is_tail);
                    else n_pass++;
                end
            end
        end
        // Pointer now sits at 3: input 3 must beat input 1.
        flit_q[1].push_back(HEAD_TAIL);
        flit_q[3].push_back(HEAD_TAIL);
        exp_q.push_back('{3, 1'b1});
        exp_q.push_back('{1, 1'b1});
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if ({o_g, o_f, o_ft} !== {eg2[c], eg2[c], eg2[c] != '0})
                $display("FAIL ptr_after_packet cyc%0d grant=%b fire=%b tail=%b required grant=%b",
                         c, o_g, o_f, o_ft, eg2[c]);
            else n_pass++;
            if (o_f != '0) begin
                n_checks++;
                if (exp_q.size() == 0)
                    $display("FAIL ptr_sb cyc%0d unexpected fire=%b", c, o_f);
                else begin
                    e = exp_q.pop_front();
                    if (o_f !== (NP'(1) << e.idx) || o_ft !== e.is_tail || o_gi !== 3'(e.idx))
                        $display("FAIL ptr_sb cyc%0d fire=%b idx=%0d required input %0d",
                                 c, o_f, o_gi, e.idx);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL packet_drain pending=%0d required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int ord [3] = '{1, 3, 4};
        logic [NP-1:0] eg;
        fire_t e;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            flit_q[1].push_back(HEAD_TAIL);
            flit_q[3].push_back(HEAD_TAIL);
            flit_q[4].push_back(HEAD_TAIL);
        end
        for (int k = 0; k < 9; k++) exp_q.push_back('{ord[k % 3], 1'b1});
        for (int c = 0; c < 18; c++) begin
            tick();
            eg = (c % 2 == 0) ? '0 : NP'(1) << ord[(c / 2) % 3];
            n_checks++;
            if ({o_g, o_l, o_f, o_ft} !== {eg, eg != '0, eg, eg != '0})
                $display("FAIL round_robin cyc%0d grant=%b locked=%b fire=%b tail=%b required grant=%b",
                         c, o_g, o_l, o_f, o_ft, eg);
            else n_pass++;
            if (o_f != '0) begin
                n_checks++;
                if (exp_q.size() == 0)
                    $display("FAIL rr_sb cyc%0d unexpected fire=%b", c, o_f);
                else begin
                    e = exp_q.pop_front();
                    if (o_f !== (NP'(1) << e.idx) || o_ft !== e.is_tail || o_gi !== 3'(e.idx))
                        $display("FAIL rr_sb cyc%0d fire=%b idx=%0d required input %0d",
                                 c, o_f, o_gi, e.idx);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL rr_drain pending=%0d required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [NP-1:0] eg [13]  = '{5'd0, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1,
                                    5'd1, 5'd1, 5'd0, 5'd16, 5'd16, 5'd0};
        logic [NP-1:0] ef [13]  = '{5'd0, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0,
                                    5'd1, 5'd1, 5'd0, 5'd16, 5'd16, 5'd0};
        logic          eft [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        fire_t e;
        apply_reset();
        flit_q[0].push_back(HEAD);
        flit_q[0].push_back(BODY);
        flit_q[0].push_back(BODY);
        flit_q[0].push_back(TAIL);
        flit_q[4].push_back(HEAD);
        flit_q[4].push_back(TAIL);
        for (int k = 0; k < 4; k++) exp_q.push_back('{0, k == 3});
        exp_q.push_back('{4, 1'b0});
        exp_q.push_back('{4, 1'b1});
        for (int c = 0; c < 13; c++) begin
            down_on     = !(c >= 3 && c <= 5);
            req_mask[0] = (c == 6);
            tick();
            n_checks++;
            if ({o_g, o_l, o_f, o_ft} !== {eg[c], eg[c] != '0, ef[c], eft[c]})
                $display("FAIL backpressure cyc%0d grant=%b locked=%b fire=%b tail=%b required grant=%b fire=%b tail=%b",
                         c, o_g, o_l, o_f, o_ft, eg[c], ef[c], eft[c]);
            else n_pass++;
            if (o_f != '0) begin
                n_checks++;
                if (exp_q.size() == 0)
                    $display("FAIL bp_sb cyc%0d unexpected fire=%b", c, o_f);
                else begin
                    e = exp_q.pop_front();
                    if (o_f !== (NP'(1) << e.idx) || o_ft !== e.is_tail || o_gi !== 3'(e.idx))
                        $display("FAIL bp_sb cyc%0d fire=%b tail=%b idx=%0d required input %0d tail=%b",
                                 c, o_f, o_ft, o_gi, e.idx, e.is_tail);
                    else n_pass++;
                end
            end
        end
        down_on  = 1'b1;
        req_mask = '0;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL bp_drain pending=%0d required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_uturn();
        apply_reset();
        b_req  = 5'b00010;
        b_head = 5'b00010;
        b_tail = 5'b00010;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if ({n_grant, n_locked, n_fire} !== '0)
                $display("FAIL uturn_masked cyc%0d grant=%b locked=%b fire=%b required zero",
                         c, n_grant, n_locked, n_fire);
            else n_pass++;
            if (c == 0) begin
                n_checks++;
                if (u_grant !== 5'b00000)
                    $display("FAIL uturn_allowed_arb grant=%b required 00000", u_grant);
                else n_pass++;
            end
            if (c == 1) begin
                n_checks++;
                if ({u_grant, u_idx, u_fire, u_fire_tail} !== {5'b00010, 3'd1, 5'b00010, 1'b1})
                    $display("FAIL uturn_allowed_grant grant=%b idx=%0d fire=%b tail=%b required grant=00010 idx=1",
                             u_grant, u_idx, u_fire, u_fire_tail);
                else n_pass++;
            end
            @(posedge clk);
            #1;
        end
        b_req  = '0;
        b_head = '0;
        b_tail = '0;
    endtask

    task automatic test_reset_mid_packet();
        logic [NP-1:0] eg [5]  = '{5'd0, 5'd2, 5'd0, 5'd8, 5'd8};
        logic          eft [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [NP-1:0] eg2 [5] = '{5'd0, 5'd1, 5'd0, 5'd8, 5'd0};
        fire_t e;
        apply_reset();
        flit_q[1].push_back(HEAD_TAIL);
        flit_q[3].push_back(HEAD);
        flit_q[3].push_back(BODY);
        flit_q[3].push_back(BODY);
        flit_q[3].push_back(BODY);
        flit_q[3].push_back(TAIL);
        exp_q.push_back('{1, 1'b1});
        exp_q.push_back('{3, 1'b0});
        exp_q.push_back('{3, 1'b0});
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if ({o_g, o_f, o_ft} !== {eg[c], eg[c], eft[c]})
                $display("FAIL pre_reset cyc%0d grant=%b fire=%b tail=%b required grant=%b tail=%b",
                         c, o_g, o_f, o_ft, eg[c], eft[c]);
            else n_pass++;
            if (o_f != '0) begin
                n_checks++;
                if (exp_q.size() == 0)
                    $display("FAIL pre_reset_sb cyc%0d unexpected fire=%b", c, o_f);
                else begin
                    e = exp_q.pop_front();
                    if (o_f !== (NP'(1) << e.idx) || o_ft !== e.is_tail)
                        $display("FAIL pre_reset_sb cyc%0d fire=%b required input %0d", c, o_f, e.idx);
                    else n_pass++;
                end
            end
        end
        // Body transfer in progress, then reset lands between clock edges.
        drive();
        #1;
        n_checks++;
        if (fire !== 5'b01000) $display("FAIL body_in_flight fire=%b required 01000", fire);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({grant, grant_idx, locked, fire, fire_tail} !== '0)
            $display("FAIL async_reset_drop grant=%b idx=%0d locked=%b fire=%b required all zero",
                     grant, grant_idx, locked, fire);
        else n_pass++;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        flit_q[3].delete();
        flit_q[0].push_back(HEAD_TAIL);
        flit_q[3].push_back(HEAD_TAIL);
        exp_q.push_back('{0, 1'b1});
        exp_q.push_back('{3, 1'b1});
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if ({o_g, o_f, o_ft} !== {eg2[c], eg2[c], eg2[c] != '0})
                $display("FAIL post_reset cyc%0d grant=%b fire=%b tail=%b required grant=%b",
                         c, o_g, o_f, o_ft, eg2[c]);
            else n_pass++;
            if (o_f != '0) begin
                n_checks++;
                if (exp_q.size() == 0)
                    $display("FAIL post_reset_sb cyc%0d unexpected fire=%b", c, o_f);
                else begin
                    e = exp_q.pop_front();
                    if (o_f !== (NP'(1) << e.idx) || o_ft !== e.is_tail || o_gi !== 3'(e.idx))
                        $display("FAIL post_reset_sb cyc%0d fire=%b idx=%0d required input %0d",
                                 c, o_f, o_gi, e.idx);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL post_reset_drain pending=%0d required 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        req      = '0;
        head     = '0;
        tail     = '0;
        down_on  = 1'b1;
        req_mask = '0;
        b_req    = '0;
        b_head   = '0;
        b_tail   = '0;
        test_reset();
        test_packet();
        test_round_robin();
        test_backpressure();
        test_uturn();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
